pipe_skid_stage: RTL
====================

// Module: pipe_skid_stage
// PURPOSE
//  Two-entry registered pipeline stage with valid/ready handshake (skid buffer).
//  Built on the plain non-reset data-register primitive; only control state is reset.
//  Sits between two pipeline stages (e.g. fetch->decode, decode->issue).
//  Breaks the ready path combinationally and sustains 1 transfer/cycle.
//  Supports a synchronous flush for pipeline redirect.
// PARAMETERS
//  DW  64  payload width in bits (must be >= 1)
// PORTS
//  CLK      in   1    clock; all state updates on posedge
//  RST      in   1    asynchronous, active-high reset
//  i_flush  in   1    synchronous flush; discards all held entries
//  i_valid  in   1    upstream payload valid
//  o_ready  out  1    stage can accept; driven from a register only
//  i_data   in   DW   upstream payload
//  o_valid  out  1    downstream payload valid; driven from a register only
//  i_ready  in   1    downstream accepts o_data this cycle
//  o_data   out  DW   downstream payload; driven from the main data register
//  o_count  out  2    occupancy: 0, 1 or 2
// BEHAVIOUR
//  Handshake events:
//   - accept  = i_valid & o_ready & ~i_flush
//   - deliver = o_valid & i_ready
//  States, one-hot or encoded:
//   - EMPTY: o_valid=0, o_ready=1, o_count=0
//   - BUSY:  o_valid=1, o_ready=1, o_count=1
//   - FULL:  o_valid=1, o_ready=0, o_count=2
//  Transitions; i_flush has priority over all of them:
//   - any state, i_flush=1 -> EMPTY next cycle; data registers are left unchanged
//   - EMPTY, accept -> BUSY; main <= i_data
//   - BUSY, accept & deliver -> BUSY; main <= i_data
//   - BUSY, accept & ~deliver -> FULL; skid <= i_data, main is held
//   - BUSY, ~accept & deliver -> EMPTY
//   - FULL, deliver -> BUSY; main <= skid. No accept is possible because o_ready=0.
//   - no event -> hold state and data
//  Timing and ordering:
//   - Latency: a payload accepted at edge N is visible on o_data/o_valid after edge N.
//   - Order is strictly FIFO. Nothing is duplicated or dropped except by flush or reset.
//  Data registers:
//   - Main and skid data registers have no reset.
//   - Simulation initialises them to random values.
//   - o_data is don't-care while o_valid=0.
//  Reset:
//   - RST asserted at any time forces EMPTY immediately: o_valid=0, o_ready=1, o_count=0.
//   - This includes reset mid-transfer; in-flight payloads are lost.
//   - Leaving reset makes no transfer until the first accept.
//  Upstream obligations:
//   - i_data must stay stable while i_valid=1 and o_ready=0.
//   - Upstream sees the same i_flush and must drop its own payload.
//   - During i_flush, o_ready may read 1 but no accept occurs.
//  Simultaneous flush and deliver: the downstream transfer completes, then the stage is EMPTY.
//  Assertions (under NCPU_ENABLE_ASSERT):
//   - o_count == 2 implies o_ready == 0.
//   - o_valid == 0 implies o_count == 0.
//   - X on i_valid, i_ready or i_flush outside reset is fatal.
// TESTING
//  1. Streaming: i_valid=1 and i_ready=1 every cycle, i_data=1,2,3...
//     -> o_data=1,2,3... each one cycle later; o_count stays 1; o_ready stays 1.
//  2. Backpressure: i_ready=0, push 0xA then 0xB.
//     -> o_count=2, o_ready=0, o_data=0xA.
//     Raise i_ready -> 0xA then 0xB delivered in consecutive cycles, then EMPTY.
//  3. Stall then fill: FULL with 0xA,0xB, hold i_valid=1 with 0xC.
//     -> 0xC is not accepted until o_ready returns to 1; output order is 0xA, 0xB, 0xC.
//  4. Flush: FULL, pulse i_flush with i_valid=1 and data 0xD.
//     -> next cycle o_valid=0, o_count=0, and 0xD never appears.
//  5. Flush with deliver: BUSY with 0x5, i_ready=1 and i_flush=1 in the same cycle.
//     -> 0x5 is counted as delivered; the stage is EMPTY next cycle.
//  6. Async reset: assert RST between clock edges while FULL.
//     -> o_valid=0, o_ready=1, o_count=0 before the next edge.
//     After release, pushing 0x7 -> o_data=0x7 one cycle later.

Source files
------------

// File: rtl/pipe_skid_stage.sv
// Two-entry skid-buffer pipeline stage with valid/ready handshake and synchronous flush.
// o_valid/o_ready are direct state-register bits, so neither output depends combinationally on i_ready.
module pipe_skid_stage #(
  parameter int DW = 64
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          i_flush,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_data,
  output logic [1:0]    o_count
);

  // State encoding is {ready, valid}; each handshake output is one register bit.
  typedef enum logic [1:0] {
    ST_FULL  = 2'b01,
    ST_EMPTY = 2'b10,
    ST_BUSY  = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          accept;
  logic          deliver;

  assign o_ready = state_q[1];
  assign o_valid = state_q[0];
  assign o_data  = main_q;
  assign o_count = {~state_q[1], state_q[1] & state_q[0]};

  assign accept  = i_valid & o_ready & ~i_flush;
  assign deliver = o_valid & i_ready;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (i_flush) begin
      // A deliver in the same cycle still completes downstream; the stage just ends up empty.
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_BUSY;
            main_d  = i_data;
          end
        end
        ST_BUSY: begin
          if (accept && deliver) begin
            main_d = i_data;
          end else if (accept) begin
            state_d = ST_FULL;
            skid_d  = i_data;
          end else if (deliver) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (deliver) begin
            state_d = ST_BUSY;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // NOTE: payload registers are deliberately not reset; o_data is only meaningful while o_valid=1.
  always_ff @(posedge CLK) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end

`ifdef NCPU_ENABLE_ASSERT
  a_full_not_ready: assert property (@(posedge CLK) disable iff (RST)
    (o_count == 2'd2) |-> !o_ready);
  a_idle_empty: assert property (@(posedge CLK) disable iff (RST)
    !o_valid |-> (o_count == 2'd0));
  a_ctrl_known: assert property (@(posedge CLK) disable iff (RST)
    !$isunknown({i_valid, i_ready, i_flush}))
    else $fatal(1, "unknown value on handshake/flush input");
`endif

endmodule
